// File: rtl/fv_ccp_rdrsp_pkg.sv
// fv_ccp_rdrsp_pkg
// Shared definitions for the read-response tracker: indices of the sticky
// error bits within each port's error field, the expected-command record
// held in the per-port queues, and a helper that builds that record.
package fv_ccp_rdrsp_pkg;

  // Width of the per-port error field and the meaning of each bit
  localparam int ERR_W             = 6;
  localparam int ERR_UNEXPECTED    = 0;
  localparam int ERR_VALID_DROP    = 1;
  localparam int ERR_PAYLOAD_CHG   = 2;
  localparam int ERR_LAST_MISMATCH = 3;
  localparam int ERR_BYTEEN        = 4;
  localparam int ERR_OVERFLOW      = 5;

  // Packages cannot be parameterised, so the command record stores the
  // burst length at a fixed maximum width and the tracker zero-extends its
  // BURST_LEN_W-bit fields into it. BURST_LEN_W must not exceed this.
  localparam int MAX_BURST_LEN_W = 8;

  typedef struct packed {
    logic [MAX_BURST_LEN_W-1:0] burst_len;   // beats-1
    logic                       full_byteen; // every beat must have all byte enables set
  } cmd_t;

  function automatic cmd_t make_cmd(input logic [MAX_BURST_LEN_W-1:0] burst_len,
                                    input logic                       full_byteen);
    cmd_t c;
    c.burst_len   = burst_len;
    c.full_byteen = full_byteen;
    return c;
  endfunction

endpackage

// File: rtl/fv_ccp_cmd_fifo.sv
// fv_ccp_cmd_fifo
// Expected-command queue for one response port. Supports a push and a pop
// in the same cycle, including a push into a full queue when a pop frees
// the slot that cycle. A push into a full queue without a pop is dropped;
// a pop from an empty queue is ignored.
//
// Ports
//   clk, reset_n : clock and asynchronous active-low reset
//   push         : write push_data at the tail
//   push_data    : command to enqueue
//   pop          : discard the head entry
//   head_data    : current head entry (undefined content when empty)
//   full, empty  : queue status
//   count        : number of stored entries
module fv_ccp_cmd_fifo
  import fv_ccp_rdrsp_pkg::*;
#(
  parameter int DEPTH = 24,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  cmd_t             push_data,
  input  logic             pop,
  output cmd_t             head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign count     = cnt_q;
  assign head_data = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a push into a full queue is
  // still accepted when it coincides with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fv_ccp_rdrsp_tracker.sv
// fv_ccp_rdrsp_tracker
// Protocol checker for N_PORTS independent read-response channels. Each
// port queues expected responses (burst length, full-byte-enable flag) and
// checks the response stream against them, raising sticky error bits:
//   bit 0 unexpected response, bit 1 valid dropped during a stall,
//   bit 2 payload changed during a stall, bit 3 rsp_last mismatch,
//   bit 4 byte enables not all ones, bit 5 command queue overflow.
//
// Optional feature (macro FV_CCP_RDRSP_CANCEL_EN): an accepted final beat
// carrying rsp_cancel rewinds the beat counter without retiring the
// command, so the whole burst is expected again. Without the macro,
// rsp_cancel only participates in the stall hold check.
//
// Ports
//   clk, reset_n    : clock and asynchronous active-low reset
//   cmd_valid       : per port, push one expected response
//   cmd_burst_len   : per port, expected beats-1
//   cmd_full_byteen : per port, response beats must have all byte enables
//   rsp_valid/ready : per port response handshake
//   rsp_last        : per port final-beat marker
//   rsp_cancel      : per port cancel qualifier
//   rsp_byteen      : per port byte enables
//   rsp_data        : per port response data
//   err             : per port sticky error field (6 bits each)
//   err_any         : OR of all err bits
//   outstanding     : per port queued command count
module fv_ccp_rdrsp_tracker
  import fv_ccp_rdrsp_pkg::*;
#(
  parameter int N_PORTS     = 2,
  parameter int DATA_W      = 128,
  parameter int BYTE_EN_W   = DATA_W / 8,
  parameter int BURST_LEN_W = 2,
  parameter int CMD_DEPTH   = 24
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [N_PORTS-1:0]                     cmd_valid,
  input  logic [N_PORTS*BURST_LEN_W-1:0]         cmd_burst_len,
  input  logic [N_PORTS-1:0]                     cmd_full_byteen,
  input  logic [N_PORTS-1:0]                     rsp_valid,
  input  logic [N_PORTS-1:0]                     rsp_ready,
  input  logic [N_PORTS-1:0]                     rsp_last,
  input  logic [N_PORTS-1:0]                     rsp_cancel,
  input  logic [N_PORTS*BYTE_EN_W-1:0]           rsp_byteen,
  input  logic [N_PORTS*DATA_W-1:0]              rsp_data,
  output logic [N_PORTS*ERR_W-1:0]               err,
  output logic                                   err_any,
  output logic [N_PORTS*$clog2(CMD_DEPTH+1)-1:0] outstanding
);

  localparam int CNT_W = $clog2(CMD_DEPTH + 1);

`ifdef FV_CCP_RDRSP_CANCEL_EN
  localparam logic CANCEL_EN = 1'b1;
`else
  localparam logic CANCEL_EN = 1'b0;
`endif

  // Next value of every port's sticky error field; err_any is registered
  // from this so it lines up with err in the same cycle.
  logic [N_PORTS*ERR_W-1:0] err_next;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port

    cmd_t                 push_cmd;
    cmd_t                 fifo_head;
    cmd_t                 head_cmd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_push;
    logic                 fifo_pop;

    logic                 head_valid;
    logic                 accepted;
    logic                 at_last;
    logic                 final_beat;
    logic                 cancel_hit;
    logic                 pop_head;
    logic [BURST_LEN_W-1:0]     beat_cnt;
    logic [MAX_BURST_LEN_W-1:0] beat_cnt_ext;

    logic                 stall_q;
    logic                 last_q;
    logic                 cancel_q;
    logic [BYTE_EN_W-1:0] byteen_q;
    logic [DATA_W-1:0]    data_q;

    logic [BYTE_EN_W-1:0] byteen_in;
    logic [DATA_W-1:0]    data_in;
    logic [ERR_W-1:0]     err_now;
    logic [ERR_W-1:0]     err_q;

    assign byteen_in = rsp_byteen[p*BYTE_EN_W +: BYTE_EN_W];
    assign data_in   = rsp_data[p*DATA_W +: DATA_W];
    assign push_cmd  = make_cmd(MAX_BURST_LEN_W'(cmd_burst_len[p*BURST_LEN_W +: BURST_LEN_W]),
                                cmd_full_byteen[p]);

    // With an empty queue the command pushed this cycle is the head, so a
    // response may complete in the same cycle its command arrives.
    assign head_valid   = ~fifo_empty | cmd_valid[p];
    assign head_cmd     = fifo_empty ? push_cmd : fifo_head;
    assign accepted     = rsp_valid[p] & rsp_ready[p];
    assign beat_cnt_ext = MAX_BURST_LEN_W'(beat_cnt);
    assign at_last      = (beat_cnt_ext == head_cmd.burst_len);
    assign final_beat   = accepted & head_valid & at_last;
    assign cancel_hit   = CANCEL_EN & final_beat & rsp_cancel[p];
    assign pop_head     = final_beat & ~cancel_hit;

    // A bypassed command that completes immediately never enters the
    // queue; otherwise the queue sees the raw push and the head pop.
    assign fifo_push = cmd_valid[p] & ~(fifo_empty & pop_head);
    assign fifo_pop  = pop_head & ~fifo_empty;

    fv_ccp_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .CNT_W (CNT_W)
    ) u_cmd_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (push_cmd),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
    );

    assign outstanding[p*CNT_W +: CNT_W] = fifo_count;

    always_comb begin
      err_now = '0;
      err_now[ERR_UNEXPECTED]    = rsp_valid[p] & ~head_valid;
      err_now[ERR_VALID_DROP]    = stall_q & ~rsp_valid[p];
      err_now[ERR_PAYLOAD_CHG]   = stall_q & ((rsp_last[p]   != last_q)   |
                                              (rsp_cancel[p] != cancel_q) |
                                              (byteen_in     != byteen_q) |
                                              (data_in       != data_q));
      err_now[ERR_LAST_MISMATCH] = accepted & head_valid & (rsp_last[p] != at_last);
      err_now[ERR_BYTEEN]        = rsp_valid[p] & head_valid & head_cmd.full_byteen &
                                   (byteen_in != {BYTE_EN_W{1'b1}});
      err_now[ERR_OVERFLOW]      = cmd_valid[p] & fifo_full & ~fifo_pop;
    end

    assign err_next[p*ERR_W +: ERR_W] = err_q | err_now;
    assign err[p*ERR_W +: ERR_W]      = err_q;

    // Beat counter advances on accepted beats that belong to a command and
    // returns to zero after the final beat (retired or cancelled). The
    // stall history captures the payload every cycle; it only matters in
    // the cycle after a stall.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        beat_cnt <= '0;
        stall_q  <= 1'b0;
        last_q   <= 1'b0;
        cancel_q <= 1'b0;
        byteen_q <= '0;
        data_q   <= '0;
        err_q    <= '0;
      end else begin
        if (accepted & head_valid) begin
          beat_cnt <= at_last ? '0 : beat_cnt + 1'b1;
        end
        stall_q  <= rsp_valid[p] & ~rsp_ready[p];
        last_q   <= rsp_last[p];
        cancel_q <= rsp_cancel[p];
        byteen_q <= byteen_in;
        data_q   <= data_in;
        err_q    <= err_q | err_now;
      end
    end

  end : g_port

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_any <= 1'b0;
    end else begin
      err_any <= |err_next;
    end
  end

endmodule

// File: doc/fv_ccp_rdrsp_tracker.md
FV_CCP_RDRSP_TRACKER -- requirements
Module: fv_ccp_rdrsp_tracker

Interface
REQ-001 SHALL have parameter N_PORTS, default 2: number of independent read-response channels.
REQ-002 SHALL have parameter DATA_W, default 128: response data width per port.
REQ-003 SHALL have parameter BYTE_EN_W, default DATA_W/8: byte-enable width per port.
REQ-004 SHALL have parameter BURST_LEN_W, default 2: burst-length field width, encoded as beats-1.
REQ-005 SHALL have parameter CMD_DEPTH, default 24: expected-command queue depth per port.
REQ-006 SHALL have port clk, input, 1: clock, all logic rising-edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port cmd_valid, input, N_PORTS: push one expected response per port.
REQ-009 SHALL have port cmd_burst_len, input, N_PORTS*BURST_LEN_W: expected beats-1 per port.
REQ-010 SHALL have port cmd_full_byteen, input, N_PORTS: 1 = read-only/write-through, byteen must be all ones.
REQ-011 SHALL have ports rsp_valid, rsp_ready, rsp_last and rsp_cancel, each input, N_PORTS: response handshake and qualifiers.
REQ-012 SHALL have ports rsp_byteen, input, N_PORTS*BYTE_EN_W, and rsp_data, input, N_PORTS*DATA_W: response payload.
REQ-013 SHALL have port err, output, N_PORTS*6: sticky error bits per port.
REQ-014 SHALL have port err_any, output, 1: OR of all err bits.
REQ-015 SHALL have port outstanding, output, N_PORTS*$clog2(CMD_DEPTH+1): queued command count per port.

Function
REQ-016 SHALL treat a beat as accepted when rsp_valid & rsp_ready on that port.
REQ-017 SHALL use head command = queue head, or the same-cycle pushed command when the queue is empty (bypass).
REQ-018 SHALL keep a BURST_LEN_W-bit beat counter per port: +1 per accepted beat, 0 after the last accepted beat.
REQ-019 SHALL pop the head when an accepted beat has beat counter == head burst_len; push and pop in one cycle SHALL leave outstanding unchanged.
REQ-020 SHALL set err bit 0 (unexpected) when rsp_valid=1 and no head command exists.
REQ-021 SHALL set err bit 1 (valid drop) when rsp_valid & !rsp_ready in cycle N and rsp_valid=0 in cycle N+1.
REQ-022 SHALL set err bit 2 (payload change) when the cycle-N stall is followed in N+1 by any change of last, byteen, data or cancel.
REQ-023 SHALL set err bit 3 (last mismatch) when on an accepted beat rsp_last differs from (beat counter == head burst_len).
REQ-024 SHALL set err bit 4 (byteen) when rsp_valid, head cmd_full_byteen=1, and rsp_byteen is not all ones.
REQ-025 SHALL set err bit 5 (overflow) on a push into a full queue with no pop that cycle; that command SHALL be dropped.
REQ-026 SHALL hold err bits sticky until reset; err and err_any SHALL be registered, one cycle after the violating cycle.
REQ-027 SHALL keep ports fully independent; no cross-port ordering is checked.

Reset
REQ-028 SHALL asynchronously clear queues, beat counters, stall history, err, err_any and outstanding to 0 when reset_n=0.
REQ-029 SHALL discard in-flight bursts on reset mid-operation and SHALL flag no error on the first cycle after release.

Configuration
REQ-030 With FV_CCP_RDRSP_CANCEL_EN defined, an accepted last beat with rsp_cancel=1 SHALL reset the beat counter without popping, so the burst is re-expected.
REQ-031 With FV_CCP_RDRSP_CANCEL_EN undefined, rsp_cancel SHALL be ignored except for the REQ-022 hold check.

Structure
REQ-032 SHALL place the error-bit index constants and the command struct (burst_len, full_byteen) in package fv_ccp_rdrsp_pkg.
REQ-033 SHALL instantiate one sub-module fv_ccp_cmd_fifo per port: a parametrised FIFO with full, empty, count and same-cycle push/pop.

Verification
REQ-034 SHALL test: port0 push burst_len=3, four beats with last on beat 4, ready=1 -> err=0, outstanding 1->0.
REQ-035 SHALL test: rsp_valid=1 on port1 with empty queue -> err[1*6+0]=1 next cycle, err_any=1.
REQ-036 SHALL test: valid=1, ready=0, data 0xA5 then 0x5A next cycle -> err bit 2 set.
REQ-037 SHALL test: 25 pushes to port0 with no responses and CMD_DEPTH=24 -> err bit 5 set, outstanding=24.
REQ-038 SHALL test: full_byteen=1 command, beat with byteen=0xFFFE -> err bit 4 set; same with full_byteen=0 -> no error.
REQ-039 SHALL test, with FV_CCP_RDRSP_CANCEL_EN: burst_len=1 with a cancelled last beat, then 2 clean beats -> err=0, one pop only.
